branch_resolve_unit: RTL
========================

# branch_resolve_unit

Parametrised branch prediction and resolution unit for the RISC-V pipeline. Fetch queries a table of saturating counters indexed by PC to get a taken/not-taken prediction. Execute presents the branch type and ALU flags, and the unit evaluates the condition, trains the counter and reports any mispredict. On a mispredict it also supplies the redirect PC. All responses are registered, so each path has one cycle of latency.

## Interface
Parameters:
- XLEN, 32, PC/target width
- BHT_ENTRIES, 64, counter table depth; power of two, ≥ 2
- CTR_BITS, 2, saturating counter width; 1..4

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  drops responses currently being registered
- pred_valid  in  1  fetch query
- pred_pc  in  XLEN  fetch PC
- pred_rsp_valid  out  1  prediction response valid
- pred_taken  out  1  predicted direction
- res_valid  in  1  execute resolution request
- res_pc  in  XLEN  branch PC
- res_branch_type  in  3  NONE=0, BEQ=1, BNE=2, BLT=3, BGE=4, BLTU=5, BGEU=6; 7 reserved
- zero, neg, c_out, over  in  1 each  ALU flags from the compare subtraction
- res_pred_taken  in  1  prediction originally given for this branch
- res_target  in  XLEN  computed taken target
- res_rsp_valid  out  1  resolution response valid
- res_taken  out  1  actual direction
- mispredict  out  1  res_taken != res_pred_taken
- redirect_pc  out  XLEN  correct next PC; meaningful only when mispredict=1

## Operation
- Index = pc[$clog2(BHT_ENTRIES)+1:2]. No tags; aliasing is permitted.
- Counter predicts taken when its MSB = 1.
- Condition evaluation:
  - BEQ: zero
  - BNE: !zero
  - BLT: neg^over
  - BGE: !(neg^over)
  - BLTU: !c_out
  - BGEU: c_out
  - NONE and 7: not taken
- Training occurs on res_valid with a conditional type (1..6). Taken increments the counter, not taken decrements it, and both saturate at 0 and 2^CTR_BITS-1.
- NONE and 7 never train. They still report mispredict if res_pred_taken=1, with redirect_pc = res_pc+4.
- redirect_pc = res_taken ? res_target : res_pc+4. Arithmetic is modulo 2^XLEN, so PC wrap-around is allowed.
- Same-cycle prediction read and training write to the same index: the prediction uses the pre-update value.
- flush=1 forces pred_rsp_valid and res_rsp_valid to 0 on the next edge. Table state is unaffected, and training on the flush cycle still occurs.

## Timing
- Query at edge N gives pred_rsp_valid/pred_taken valid after edge N+1.
- Resolution at edge N gives the res_* response, mispredict and redirect_pc after edge N+1.
- The counter write commits at edge N+1 and is visible to queries sampled at N+1 or later.
- Outputs deassert (valid=0) on cycles with no request; data outputs hold their last value.
- Reset values:
  - All counters = 2^(CTR_BITS-1)-1 (weakly not taken; 01 for CTR_BITS=2)
  - All outputs = 0, including redirect_pc
- Reset mid-operation discards all in-flight responses immediately (asynchronously).

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each conditional resolution; stat_mispredicts increments on each res_valid with mismatch.
  - Both saturate at 2^32-1, reset to 0 and ignore flush.
- BRANCH_STATS_EN undefined: neither port nor counter exists.

## Structure
- branch_pkg holds:
  - branch_type_e enum (codes above)
  - ctr_init(CTR_BITS) function
  - ctr_next(ctr, taken) saturating-step function
- Sub-module branch_cond_eval: combinational evaluation of type plus flags into taken.
- Top level contains the counter array, the response registers and the stats counters.

## Test plan
- Reset with CTR_BITS=2, then query pc=0x100: pred_rsp_valid=1 next cycle, pred_taken=0.
- Two resolutions of BEQ with zero=1 at pc=0x100 (res_pred_taken=0, target 0x80):
  - Both give mispredict=1, redirect_pc=0x80.
  - Next query at pc=0x100 predicts taken (counter 01→10→11).
  - A third taken resolution leaves the counter at 11 (saturation).
- BLT with neg=1, over=1 at pc=0x200, res_pred_taken=1: res_taken=0, mispredict=1, redirect_pc=0x204.
- Alias check with BHT_ENTRIES=64: training pc=0x100 affects pc=0x200; same-cycle query and train at pc=0x100 returns the old value.
- NONE with res_pred_taken=1 at pc=0xFFFF_FFFC: mispredict=1, redirect_pc=0x0, no counter change.
- Assert flush with concurrent requests: no valid responses follow. Then reset mid-stream: outputs go to 0 at once and counters return to 01. With BRANCH_STATS_EN defined, 3 branches with 2 mispredicts read 3/2.

Source files
------------

// File: rtl/branch_pkg.sv
// branch_pkg: branch type codes and saturating-counter helpers for branch_resolve_unit
package branch_pkg;
  typedef enum logic [2:0] {
    NONE = 3'd0,
    BEQ  = 3'd1,
    BNE  = 3'd2,
    BLT  = 3'd3,
    BGE  = 3'd4,
    BLTU = 3'd5,
    BGEU = 3'd6,
    RSVD = 3'd7
  } branch_type_e;
  typedef logic [3:0] ctr_t;
  function automatic ctr_t ctr_init(input int bits);
    return ctr_t'((1 << (bits - 1)) - 1);
  endfunction
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken, input int bits = 2);
    ctr_t top;
    top = ctr_t'((1 << bits) - 1);
    return taken ? ((ctr == top) ? ctr : ctr + 1'b1) : ((ctr == '0) ? ctr : ctr - 1'b1);
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: maps branch type and ALU compare flags to the actual branch direction
module branch_cond_eval
  import branch_pkg::*;
(
  input  branch_type_e br_type,
  input  logic         zero,
  input  logic         neg,
  input  logic         c_out,
  input  logic         over,
  output logic         taken,
  output logic         is_cond
);
  logic lt;
  assign lt = neg ^ over;
  always_comb begin
    taken = br_type == BEQ  ? zero   :
            br_type == BNE  ? !zero  :
            br_type == BLT  ? lt     :
            br_type == BGE  ? !lt    :
            br_type == BLTU ? !c_out :
            br_type == BGEU ? c_out  : 1'b0;
    is_cond = (br_type != NONE) && (br_type != RSVD);
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: counter-table branch predictor plus resolution/redirect; BRANCH_STATS_EN adds stat counters
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            pred_valid,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_rsp_valid,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic [2:0]      res_branch_type,
  input  logic            zero,
  input  logic            neg,
  input  logic            c_out,
  input  logic            over,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            res_rsp_valid,
  output logic            res_taken,
  output logic            mispredict,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic [XLEN-1:0] redirect_pc
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
  logic [IW-1:0] pidx, ridx;
  logic cond_taken, is_cond, mp, unused_pc;
  assign pidx = pred_pc[IW+1:2];
  assign ridx = res_pc[IW+1:2];
  assign mp = cond_taken ^ res_pred_taken;
  assign unused_pc = ^{pred_pc[XLEN-1:IW+2], pred_pc[1:0]};
  branch_cond_eval u_cond (
    .br_type (branch_type_e'(res_branch_type)),
    .zero    (zero),
    .neg     (neg),
    .c_out   (c_out),
    .over    (over),
    .taken   (cond_taken),
    .is_cond (is_cond)
  );
  // The prediction read below sees the table before this edge's training write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_BITS'(ctr_init(CTR_BITS));
      pred_rsp_valid <= 1'b0;
      pred_taken     <= 1'b0;
      res_rsp_valid  <= 1'b0;
      res_taken      <= 1'b0;
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      pred_rsp_valid <= pred_valid && !flush;
      res_rsp_valid  <= res_valid && !flush;
      if (pred_valid) pred_taken <= bht[pidx][CTR_BITS-1];
      if (res_valid) begin
        res_taken   <= cond_taken;
        mispredict  <= mp;
        redirect_pc <= cond_taken ? res_target : res_pc + XLEN'(4);
      end
      if (res_valid && is_cond) bht[ridx] <= CTR_BITS'(ctr_next(ctr_t'(bht[ridx]), cond_taken, CTR_BITS));
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_valid && is_cond && stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (res_valid && mp && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`endif
endmodule
